// File: rtl/alu_pkg.sv
// Shared types and constants for the ID/EX pipeline stage.
// Holds the ALU control encodings, the registered ID/EX payload struct,
// the stage occupancy state and a register-match helper that keeps
// x0 out of every forwarding and hazard comparison.
package alu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    // Everything captured from decode on a transfer. op_a/op_b already
    // carry the operand-select result; rs1/rs2 and the select flags are
    // kept so the output forward mux knows which operands came from the
    // register file.
    typedef struct packed {
        logic [XLEN-1:0]       op_a;
        logic [XLEN-1:0]       op_b;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  op1_pc;
        logic                  op2_imm;
        logic                  reg_write;
        alu_ctrl_e             alu_ctrl;
    } id_ex_payload_t;

    // True when a pending write to wr_rd produces the value rs wants.
    // x0 is hard-wired to zero, so it never matches.
    function automatic logic reg_hit(
        input logic                  we,
        input logic [REG_ADDR_W-1:0] wr_rd,
        input logic [REG_ADDR_W-1:0] rs
    );
        return we && (wr_rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding mux for the ID/EX stage output.
// EX/MEM has priority over MEM/WB; if neither matches, or the operand
// came from pc/imm instead of a register, the registered value passes.
module fwd_mux
    import alu_pkg::*;
(
    input  logic                  i_use_reg,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [XLEN-1:0]       i_raw,
    input  logic                  i_exm_we,
    input  logic [REG_ADDR_W-1:0] i_exm_rd,
    input  logic [XLEN-1:0]       i_exm_data,
    input  logic                  i_mwb_we,
    input  logic [REG_ADDR_W-1:0] i_mwb_rd,
    input  logic [XLEN-1:0]       i_mwb_data,
    output logic [XLEN-1:0]       o_operand
);

    // Priority select: youngest producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        o_operand = i_raw;
        if (i_use_reg) begin
            if (reg_hit(i_exm_we, i_exm_rd, i_rs)) begin
                o_operand = i_exm_data;
            end else if (reg_hit(i_mwb_we, i_mwb_rd, i_rs)) begin
                o_operand = i_mwb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshakes on both sides.
// Build option ALU_FWD_EN: when defined, EX/MEM and MEM/WB results are
// forwarded onto ex_op1/ex_op2 and decode never stalls on data hazards;
// when undefined, there are no forward muxes and decode is held off while
// any used source register has a write still in flight.
module id_ex_stage
    import alu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    // decode side
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [3:0]            id_alu_ctrl,
    input  logic                  id_op1_pc,
    input  logic                  id_op2_imm,
    input  logic                  id_reg_write,
    // later-stage write-back sources
    input  logic [REG_ADDR_W-1:0] exm_rd,
    input  logic                  exm_reg_write,
    input  logic [XLEN-1:0]       exm_result,
    input  logic [REG_ADDR_W-1:0] mwb_rd,
    input  logic                  mwb_reg_write,
    input  logic [XLEN-1:0]       mwb_result,
    input  logic                  flush,
    // ALU side
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [XLEN-1:0]       ex_op1,
    output logic [XLEN-1:0]       ex_op2,
    output logic [3:0]            ex_alu_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic [15:0]           stall_cnt
);

    stage_state_e   r_state;
    id_ex_payload_t r_payload;
    logic [15:0]    r_stall_cnt;

    id_ex_payload_t w_payload_in;
    logic           w_hazard;
    logic           w_id_ready;
    logic           w_transfer;
    logic           w_stall_inc;

    // Capture the operand-select result at decode time and tag the write
    // enable off for x0 so nothing downstream treats it as a real write.
    always_comb begin
        w_payload_in           = '0;
        w_payload_in.op_a      = id_op1_pc  ? id_pc  : id_rs1_data;
        w_payload_in.op_b      = id_op2_imm ? id_imm : id_rs2_data;
        w_payload_in.rs1       = id_rs1;
        w_payload_in.rs2       = id_rs2;
        w_payload_in.rd        = id_rd;
        w_payload_in.op1_pc    = id_op1_pc;
        w_payload_in.op2_imm   = id_op2_imm;
        w_payload_in.reg_write = id_reg_write && (id_rd != '0);
        w_payload_in.alu_ctrl  = alu_ctrl_e'(id_alu_ctrl);
    end

`ifdef ALU_FWD_EN
    // Forwarding resolves every RAW dependency, so decode never waits.
    assign w_hazard = 1'b0;

    logic                  w_use_reg [2];
    logic [REG_ADDR_W-1:0] w_rs      [2];
    logic [XLEN-1:0]       w_raw     [2];
    logic [XLEN-1:0]       w_fwd     [2];

    assign w_use_reg[0] = !r_payload.op1_pc;
    assign w_use_reg[1] = !r_payload.op2_imm;
    assign w_rs[0]      = r_payload.rs1;
    assign w_rs[1]      = r_payload.rs2;
    assign w_raw[0]     = r_payload.op_a;
    assign w_raw[1]     = r_payload.op_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_mux u_fwd_mux (
                .i_use_reg  (w_use_reg[gi]),
                .i_rs       (w_rs[gi]),
                .i_raw      (w_raw[gi]),
                .i_exm_we   (exm_reg_write),
                .i_exm_rd   (exm_rd),
                .i_exm_data (exm_result),
                .i_mwb_we   (mwb_reg_write),
                .i_mwb_rd   (mwb_rd),
                .i_mwb_data (mwb_result),
                .o_operand  (w_fwd[gi])
            );
        end
    endgenerate

    assign ex_op1 = w_fwd[0];
    assign ex_op2 = w_fwd[1];
`else
    logic w_ex_pending_we;
    logic w_rs1_hazard;
    logic w_rs2_hazard;
    logic w_unused_fwd;

    // The instruction held here counts as an in-flight write only when
    // it is actually present.
    assign w_ex_pending_we = (r_state == ST_FULL) && r_payload.reg_write;

    // A source only matters if the operand select actually reads it.
    assign w_rs1_hazard = !id_op1_pc &&
        (reg_hit(w_ex_pending_we, r_payload.rd, id_rs1) ||
         reg_hit(exm_reg_write,   exm_rd,       id_rs1) ||
         reg_hit(mwb_reg_write,   mwb_rd,       id_rs1));
    assign w_rs2_hazard = !id_op2_imm &&
        (reg_hit(w_ex_pending_we, r_payload.rd, id_rs2) ||
         reg_hit(exm_reg_write,   exm_rd,       id_rs2) ||
         reg_hit(mwb_reg_write,   mwb_rd,       id_rs2));
    assign w_hazard = w_rs1_hazard || w_rs2_hazard;

    // Without forwarding the registered operands go straight out.
    assign ex_op1 = r_payload.op_a;
    assign ex_op2 = r_payload.op_b;

    // Results and source tags are only needed by the forward muxes.
    assign w_unused_fwd = ^{exm_result, mwb_result, r_payload.rs1,
                            r_payload.rs2, r_payload.op1_pc, r_payload.op2_imm};
`endif

    // Accept from decode when the slot is free or draining this cycle,
    // nothing is in the way, and we are not being flushed or reset.
    assign w_id_ready  = rst_n && ((r_state == ST_EMPTY) || ex_ready) &&
                         !w_hazard && !flush;
    assign w_transfer  = id_valid && w_id_ready;
    // Only hazard stalls are counted; backpressure and flush are not.
    assign w_stall_inc = id_valid && !w_id_ready && w_hazard;

    // Occupancy: flush empties, a transfer fills (no bubble when the old
    // entry drains the same edge), a consumed entry with nothing behind it empties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (w_transfer) begin
            r_state <= ST_FULL;
        end else if (ex_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    // Payload only changes on a transfer, so it holds under backpressure
    // and keeps its last value after draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_payload <= '0;
        end else if (w_transfer) begin
            r_payload <= w_payload_in;
        end
    end

    // Saturating count of decode cycles lost to data hazards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign id_ready     = w_id_ready;
    assign ex_valid     = (r_state == ST_FULL);
    assign ex_alu_ctrl  = r_payload.alu_ctrl;
    assign ex_rd        = r_payload.rd;
    assign ex_reg_write = r_payload.reg_write;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage; covers both ALU_FWD_EN builds.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_ctrl;
    logic        id_op1_pc, id_op2_imm, id_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_reg_write, mwb_reg_write;
    logic [31:0] exm_result, mwb_result;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_op1, ex_op2;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_ctrl(id_alu_ctrl), .id_op1_pc(id_op1_pc),
        .id_op2_imm(id_op2_imm), .id_reg_write(id_reg_write),
        .exm_rd(exm_rd), .mwb_rd(mwb_rd),
        .exm_reg_write(exm_reg_write), .mwb_reg_write(mwb_reg_write),
        .exm_result(exm_result), .mwb_result(mwb_result),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One line per accepted instruction.
    always @(posedge clk) begin
        if (rst_n && id_valid && id_ready)
            $display("XFER t=%0t rs1=%0d rs2=%0d rd=%0d alu=%0h", $time, id_rs1, id_rs2, id_rd, id_alu_ctrl);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_ctrl = 0;
        id_op1_pc = 0; id_op2_imm = 0; id_reg_write = 0;
        exm_rd = 0; mwb_rd = 0; exm_reg_write = 0; mwb_reg_write = 0;
        exm_result = 0; mwb_result = 0; flush = 0; ex_ready = 1;
    endtask

    task automatic drive_instr(input logic [4:0] rs1, input logic [31:0] rs1d,
                               input logic [4:0] rs2, input logic [31:0] rs2d,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [4:0] rd, input logic [3:0] alu,
                               input logic op1pc, input logic op2imm, input logic regw);
        id_valid = 1; id_rs1 = rs1; id_rs1_data = rs1d; id_rs2 = rs2; id_rs2_data = rs2d;
        id_imm = imm; id_pc = pc; id_rd = rd; id_alu_ctrl = alu;
        id_op1_pc = op1pc; id_op2_imm = op2imm; id_reg_write = regw;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        drive_instr(5'd1, 32'hAA, 5'd2, 32'hBB, 0, 0, 5'd3, 4'b1000, 0, 0, 1);
        flush = 1;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready: got %0h exp 0", id_ready); end
        step();
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_id_ready2: got %0h exp 0", id_ready); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0h exp 0", ex_valid); end
        checks++; if (ex_op1 !== 32'h0) begin errors++; $display("FAIL reset_ex_op1: got %0h exp 0", ex_op1); end
        checks++; if (ex_op2 !== 32'h0) begin errors++; $display("FAIL reset_ex_op2: got %0h exp 0", ex_op2); end
        checks++; if (ex_alu_ctrl !== 4'b0000) begin errors++; $display("FAIL reset_alu: got %0h exp 0", ex_alu_ctrl); end
        checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0h exp 0", ex_rd); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_regw: got %0h exp 0", ex_reg_write); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0h exp 0", stall_cnt); end
        set_idle();
        rst_n = 1;
    endtask

    task automatic test_basic();
        drive_instr(5'd5, 32'd10, 5'd6, 32'd3, 32'h0, 32'h0, 5'd1, 4'b1000, 0, 0, 1);
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL basic_id_ready: got %0h exp 1", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0h exp 1", ex_valid); end
        checks++; if (ex_op1 !== 32'd10) begin errors++; $display("FAIL basic_op1: got %0h exp a", ex_op1); end
        checks++; if (ex_op2 !== 32'd3) begin errors++; $display("FAIL basic_op2: got %0h exp 3", ex_op2); end
        checks++; if (ex_alu_ctrl !== 4'b1000) begin errors++; $display("FAIL basic_alu: got %0h exp 8", ex_alu_ctrl); end
        checks++; if (ex_rd !== 5'd1 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL basic_rd: got rd=%0d w=%0h exp rd=1 w=1", ex_rd, ex_reg_write); end
        set_idle();
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0h exp 0", ex_valid); end
        checks++; if (ex_op1 !== 32'd10) begin errors++; $display("FAIL basic_empty_op1: got %0h exp a", ex_op1); end
    endtask

    task automatic test_backpressure();
        drive_instr(5'd2, 32'h100, 5'd3, 32'h200, 32'h0, 32'h0, 5'd9, 4'b0000, 0, 0, 1);
        step();
        ex_ready = 0;
        drive_instr(5'd11, 32'hB1, 5'd12, 32'hB2, 32'h0, 32'h0, 5'd10, 4'b0110, 0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_id_ready[%0d]: got %0h exp 0", c, id_ready); end
            step();
            checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h100 || ex_op2 !== 32'h200 || ex_rd !== 5'd9)
                begin errors++; $display("FAIL bp_hold[%0d]: got v=%0h op1=%0h op2=%0h rd=%0d exp v=1 op1=100 op2=200 rd=9", c, ex_valid, ex_op1, ex_op2, ex_rd); end
            checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL bp_stall[%0d]: got %0d exp 0", c, stall_cnt); end
        end
        ex_ready = 1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0h exp 1", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'hB1 || ex_alu_ctrl !== 4'b0110)
            begin errors++; $display("FAIL bp_next: got v=%0h op1=%0h alu=%0h exp v=1 op1=b1 alu=6", ex_valid, ex_op1, ex_alu_ctrl); end
        set_idle();
        step();
    endtask

`ifdef ALU_FWD_EN
    task automatic test_forward();
        drive_instr(5'd7, 32'h11, 5'd8, 32'h22, 32'h0, 32'h0, 5'd15, 4'b0000, 0, 0, 1);
        step();
        set_idle();
        ex_ready = 0;
        exm_rd = 5'd7; exm_reg_write = 1; exm_result = 32'h55;
        mwb_rd = 5'd7; mwb_reg_write = 1; mwb_result = 32'h66;
        #1;
        checks++; if (ex_op1 !== 32'h55) begin errors++; $display("FAIL fwd_exm: got %0h exp 55", ex_op1); end
        checks++; if (ex_op2 !== 32'h22) begin errors++; $display("FAIL fwd_op2_nomatch: got %0h exp 22", ex_op2); end
        exm_reg_write = 0;
        #1;
        checks++; if (ex_op1 !== 32'h66) begin errors++; $display("FAIL fwd_mwb: got %0h exp 66", ex_op1); end
        mwb_reg_write = 0;
        #1;
        checks++; if (ex_op1 !== 32'h11) begin errors++; $display("FAIL fwd_none: got %0h exp 11", ex_op1); end
        ex_ready = 1;
        drive_instr(5'd0, 32'h33, 5'd8, 32'h22, 32'h0, 32'h0, 5'd15, 4'b0000, 0, 0, 1);
        step();
        set_idle();
        ex_ready = 0;
        exm_rd = 5'd0; exm_reg_write = 1; exm_result = 32'h55;
        mwb_rd = 5'd0; mwb_reg_write = 1; mwb_result = 32'h66;
        #1;
        checks++; if (ex_op1 !== 32'h33) begin errors++; $display("FAIL fwd_x0: got %0h exp 33", ex_op1); end
        ex_ready = 1;
        exm_reg_write = 0; mwb_reg_write = 0;
        drive_instr(5'd7, 32'h11, 5'd7, 32'h77, 32'h0, 32'h400, 5'd15, 4'b0000, 1, 0, 1);
        step();
        set_idle();
        ex_ready = 0;
        exm_rd = 5'd7; exm_reg_write = 1; exm_result = 32'h55;
        #1;
        checks++; if (ex_op1 !== 32'h400) begin errors++; $display("FAIL fwd_pc_sel: got %0h exp 400", ex_op1); end
        checks++; if (ex_op2 !== 32'h55) begin errors++; $display("FAIL fwd_op2: got %0h exp 55", ex_op2); end
        set_idle();
        step();
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL fwd_stall: got %0d exp 0", stall_cnt); end
    endtask
`else
    task automatic test_hazard();
        drive_instr(5'd4, 32'h44, 5'd9, 32'h99, 32'h0, 32'h0, 5'd13, 4'b0000, 0, 0, 1);
        exm_rd = 5'd4; exm_reg_write = 1; exm_result = 32'h1234;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL hz_id_ready[%0d]: got %0h exp 0", c, id_ready); end
            step();
            checks++; if (ex_valid !== 1'b0 || stall_cnt !== 16'(c + 1))
                begin errors++; $display("FAIL hz_stall[%0d]: got v=%0h cnt=%0d exp v=0 cnt=%0d", c, ex_valid, stall_cnt, c + 1); end
        end
        exm_reg_write = 0;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL hz_clear_ready: got %0h exp 1", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h44 || stall_cnt !== 16'd2)
            begin errors++; $display("FAIL hz_accept: got v=%0h op1=%0h cnt=%0d exp v=1 op1=44 cnt=2", ex_valid, ex_op1, stall_cnt); end
        // Dependency on the instruction held in this stage.
        drive_instr(5'd1, 32'h1, 5'd13, 32'hD, 32'h0, 32'h0, 5'd14, 4'b0100, 0, 0, 1);
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL hz_full_ready: got %0h exp 0", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b0 || stall_cnt !== 16'd3)
            begin errors++; $display("FAIL hz_full_stall: got v=%0h cnt=%0d exp v=0 cnt=3", ex_valid, stall_cnt); end
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL hz_full_clear: got %0h exp 1", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_op2 !== 32'hD || stall_cnt !== 16'd3)
            begin errors++; $display("FAIL hz_full_accept: got v=%0h op2=%0h cnt=%0d exp v=1 op2=d cnt=3", ex_valid, ex_op2, stall_cnt); end
        set_idle();
        step();
    endtask
`endif

    task automatic test_flush();
        drive_instr(5'd16, 32'hA0, 5'd17, 32'hA1, 32'h0, 32'h0, 5'd18, 4'b0101, 0, 0, 1);
        step();
        drive_instr(5'd19, 32'hC0, 5'd21, 32'hC1, 32'h0, 32'h0, 5'd0, 4'b0111, 0, 0, 1);
        ex_ready = 0;
        flush = 1;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL flush_id_ready: got %0h exp 0", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0h exp 0", ex_valid); end
        checks++; if (ex_op1 !== 32'hA0) begin errors++; $display("FAIL flush_dropped: got %0h exp a0", ex_op1); end
        flush = 0;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %0h exp 1", id_ready); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'hC0 || ex_reg_write !== 1'b0)
            begin errors++; $display("FAIL flush_reload: got v=%0h op1=%0h w=%0h exp v=1 op1=c0 w=0", ex_valid, ex_op1, ex_reg_write); end
        set_idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [3:0]  alu_tab [4] = '{4'b0001, 4'b0010, 4'b0011, 4'b1001};
        logic [31:0] op2_exp [4] = '{32'h100, 32'h1001, 32'h102, 32'h1003};
        for (int k = 0; k < 4; k++) begin
            drive_instr(5'(k + 1), 32'(16 * (k + 1)), 5'(k + 5), 32'(256 + k),
                        32'(4096 + k), 32'h0, 5'(20 + k), alu_tab[k], 0, k[0], 1);
            #1;
            checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %0h exp 1", k, id_ready); end
            step();
            checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'(16 * (k + 1)) || ex_op2 !== op2_exp[k] ||
                          ex_rd !== 5'(20 + k) || ex_alu_ctrl !== alu_tab[k])
                begin errors++; $display("FAIL b2b[%0d]: got v=%0h op1=%0h op2=%0h rd=%0d alu=%0h exp v=1 op1=%0h op2=%0h rd=%0d alu=%0h",
                      k, ex_valid, ex_op1, ex_op2, ex_rd, ex_alu_ctrl, 16 * (k + 1), op2_exp[k], 20 + k, alu_tab[k]); end
        end
        set_idle();
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0h exp 0", ex_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
`ifdef ALU_FWD_EN
        test_forward();
`else
        test_hazard();
`endif
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
